// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler: round-robin dispatch from two reservation stations to two FUs with CDB arbitration
module dispatch_scheduler #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rs1_rdy,
  input  logic [11:0] rs1_dest,
  input  logic [3:0]  rs2_rdy,
  input  logic [11:0] rs2_dest,
  output logic [3:0]  rs1_issue,
  output logic [3:0]  rs2_issue,
  output logic        fu1_busy,
  output logic        fu2_busy,
  output logic        cdb_valid,
  output logic [2:0]  cdb_tag,
  output logic        cdb_src
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      st_q[2], st_d[2];
  logic [3:0]  cnt_q[2], cnt_d[2];
  logic [2:0]  tag_q[2], tag_d[2];
  logic [1:0]  ptr_q[2], ptr_d[2];
  logic        last_q, last_d;
  logic [3:0]  rdy[2], issue[2];
  logic [11:0] dest[2];
  logic [1:0]  done, win, g;
  assign rdy[0] = rs1_rdy;
  assign rdy[1] = rs2_rdy;
  assign dest[0] = rs1_dest;
  assign dest[1] = rs2_dest;
  assign done = {st_q[1] == DONE, st_q[0] == DONE} & {2{!rst}};
  assign win[0] = done[0] & (!done[1] | last_q);
  assign win[1] = done[1] & (!done[0] | !last_q);
  assign rs1_issue = issue[0];
  assign rs2_issue = issue[1];
  assign fu1_busy = st_q[0] != IDLE && !rst;
  assign fu2_busy = st_q[1] != IDLE && !rst;
  assign cdb_valid = |win;
  assign cdb_src = win[1];
  assign cdb_tag = win[0] ? tag_q[0] : win[1] ? tag_q[1] : 3'd0;
  always_comb begin
    last_d = win[0] ? 1'b0 : win[1] ? 1'b1 : last_q;
    g = '0;
    for (int u = 0; u < 2; u++) begin
      issue[u] = '0;
      st_d[u] = st_q[u];
      cnt_d[u] = cnt_q[u];
      tag_d[u] = tag_q[u];
      ptr_d[u] = ptr_q[u];
      for (int k = 3; k >= 0; k--) begin
        g = ptr_q[u] + 2'(k);
        if (rdy[u][g] && !rst && (st_q[u] == IDLE || win[u])) begin
          issue[u] = '0;
          issue[u][g] = 1'b1;
          ptr_d[u] = g + 2'd1;
          tag_d[u] = dest[u][3*g +: 3];
        end
      end
      if (|issue[u]) begin
        st_d[u] = EXEC;
        cnt_d[u] = u == 0 ? 4'(ADD_LAT - 1) : 4'(MUL_LAT - 1);
      end else if (st_q[u] == EXEC) begin
        cnt_d[u] = cnt_q[u] - 4'd1;
        st_d[u] = cnt_q[u] == 4'd1 ? DONE : EXEC;
      end else if (win[u]) begin
        st_d[u] = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        st_q[u] <= IDLE;
        cnt_q[u] <= '0;
        tag_q[u] <= '0;
        ptr_q[u] <= '0;
      end
      last_q <= 1'b1;
    end else begin
      for (int u = 0; u < 2; u++) begin
        st_q[u] <= st_d[u];
        cnt_q[u] <= cnt_d[u];
        tag_q[u] <= tag_d[u];
        ptr_q[u] <= ptr_d[u];
      end
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb_dispatch_scheduler: scoreboard bench with a timestamp-based reference model
module tb_dispatch_scheduler;
  localparam int AL = 2;
  localparam int ML = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] rs1_rdy = '0, rs2_rdy = '0;
  logic [11:0] rs1_dest = '0, rs2_dest = '0;
  logic [3:0] rs1_issue, rs2_issue;
  logic fu1_busy, fu2_busy, cdb_valid, cdb_src;
  logic [2:0] cdb_tag;
  dispatch_scheduler #(.ADD_LAT(AL), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst),
    .rs1_rdy(rs1_rdy), .rs1_dest(rs1_dest),
    .rs2_rdy(rs2_rdy), .rs2_dest(rs2_dest),
    .rs1_issue(rs1_issue), .rs2_issue(rs2_issue),
    .fu1_busy(fu1_busy), .fu2_busy(fu2_busy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );
  always #5 clk = ~clk;
  typedef struct {int tag; int src; int cyc;} ev_t;
  ev_t exp_q[$];
  int vectors = 0, errors = 0, cyc = 0;
  bit pend[2];
  int ptag[2], rdy_at[2], ptr[2], lastw;
  logic [3:0] e_iss[2];
  bit e_busy[2];
  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", n, cyc, a, e);
    end
  endtask
  task automatic step(input bit r, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [11:0] d1, input logic [11:0] d2);
    bit dn[2], wn[2];
    logic [3:0] rv[2];
    logic [11:0] dv[2];
    int g;
    @(posedge clk);
    #1;
    rst = r; rs1_rdy = r1; rs2_rdy = r2; rs1_dest = d1; rs2_dest = d2;
    cyc++;
    rv[0] = r1; rv[1] = r2; dv[0] = d1; dv[1] = d2;
    if (r) begin
      for (int u = 0; u < 2; u++) begin
        e_iss[u] = '0; e_busy[u] = 0; pend[u] = 0; ptr[u] = 0; ptag[u] = 0;
      end
      lastw = 1;
    end else begin
      for (int u = 0; u < 2; u++) begin
        e_busy[u] = pend[u];
        dn[u] = pend[u] && cyc >= rdy_at[u];
      end
      wn[0] = dn[0] && (!dn[1] || lastw == 1);
      wn[1] = dn[1] && (!dn[0] || lastw == 0);
      for (int u = 0; u < 2; u++)
        if (wn[u]) begin
          exp_q.push_back(ev_t'{ptag[u], u, cyc});
          pend[u] = 0;
          lastw = u;
        end
      for (int u = 0; u < 2; u++) begin
        e_iss[u] = '0;
        if (!pend[u])
          for (int k = 0; k < 4; k++) begin
            g = (ptr[u] + k) % 4;
            if (rv[u][g]) begin
              e_iss[u] = 4'(1 << g);
              pend[u] = 1;
              ptag[u] = int'((dv[u] >> (3 * g)) & 12'd7);
              rdy_at[u] = cyc + (u == 1 ? ML : AL);
              ptr[u] = (g + 1) % 4;
              break;
            end
          end
      end
    end
    @(negedge clk);
    chk("rs1_issue", rs1_issue, e_iss[0]);
    chk("rs2_issue", rs2_issue, e_iss[1]);
    chk("fu1_busy", fu1_busy, e_busy[0]);
    chk("fu2_busy", fu2_busy, e_busy[1]);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (cdb_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL cdb_unexpected cycle %0d: got tag %0d src %0d, none expected", cyc, cdb_tag, cdb_src);
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag", cdb_tag, e.tag);
        chk("cdb_src", cdb_src, e.src);
        chk("cdb_cycle", cyc, e.cyc);
      end
    end else begin
      chk("cdb_idle_fields", {cdb_src, cdb_tag}, 0);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        vectors++;
        errors++;
        $display("FAIL cdb_missing cycle %0d: got no broadcast, want tag %0d src %0d", cyc, exp_q[0].tag, exp_q[0].src);
        void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    repeat (3) step(1, 4'b1111, 4'b1111, 12'hfff, 12'hfff);
    step(0, 4'b0001, 4'b0000, 12'd5, 12'd0);
    repeat (4) step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    repeat (12) step(0, 4'b1111, 4'b0000, {3'd4, 3'd3, 3'd2, 3'd1}, 12'd0);
    repeat (20) step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    step(1, 4'b0000, 4'b0000, 12'd0, 12'd0);
    step(0, 4'b0000, 4'b0001, 12'd0, 12'd6);
    step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    step(0, 4'b0001, 4'b0000, 12'd2, 12'd0);
    repeat (2) step(0, 4'b0000, 4'b0010, 12'd0, {3'd0, 3'd0, 3'd7, 3'd0});
    repeat (6) step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    step(0, 4'b0000, 4'b0001, 12'd0, 12'd3);
    step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    step(1, 4'b0000, 4'b0000, 12'd0, 12'd0);
    step(0, 4'b0000, 4'b0100, 12'd0, {3'd0, 3'd1, 3'd0, 3'd0});
    repeat (6) step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    repeat (1500)
      step($urandom_range(0, 63) == 0, 4'($urandom), 4'($urandom), 12'($urandom), 12'($urandom));
    repeat (20) step(0, 4'b0000, 4'b0000, 12'd0, 12'd0);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
